// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared types and constants for the brick collision scanner
package brick_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

    localparam int COORD_W          = 10;
    localparam int BRICK_SIZE_DEF   = 16;
    localparam int EBULLET_SIZE_DEF = 4;

endpackage

// File: rtl/brick_overlap.sv
// rtl/brick_overlap.sv - combinational box-versus-brick overlap test
// Box coordinates arrive 11 bits wide so an enemy box near the screen edge cannot wrap.
module brick_overlap import brick_pkg::*; #(
    parameter int BRICK_SIZE = BRICK_SIZE_DEF
) (
    input  logic [COORD_W:0]   box_l,
    input  logic [COORD_W:0]   box_r,
    input  logic [COORD_W:0]   box_t,
    input  logic [COORD_W:0]   box_b,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               overlap
);

    localparam logic [COORD_W:0] EDGE = (COORD_W+1)'(BRICK_SIZE - 1);

    logic [COORD_W:0] bx_w;
    logic [COORD_W:0] by_w;
    logic [COORD_W:0] bx_end;
    logic [COORD_W:0] by_end;

    assign bx_w   = {1'b0, bx};
    assign by_w   = {1'b0, by};
    assign bx_end = bx_w + EDGE;
    assign by_end = by_w + EDGE;

    assign overlap = (box_t < by_end) && (box_b > by_w) &&
                     (box_l < bx_end) && (box_r > bx_w);

endmodule

// File: rtl/brick_scan_ctrl.sv
// rtl/brick_scan_ctrl.sv - per-frame brick scan, alive bitmap and hit arbitration
// Optional BRICK_SCAN_OVERRUN_EN adds overrun_cnt counting ticks dropped while busy.
module brick_scan_ctrl import brick_pkg::*; #(
    parameter  int NUM_BRICK    = 100,
    parameter  int BRICK_SIZE   = BRICK_SIZE_DEF,
    parameter  int EBULLET_SIZE = EBULLET_SIZE_DEF,
    localparam int IDX_W        = $clog2(NUM_BRICK)
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 refresh_tick,
    input  logic                 load_map,
    input  logic                 pb_active,
    input  logic [COORD_W-1:0]   x_bullet_l,
    input  logic [COORD_W-1:0]   x_bullet_r,
    input  logic [COORD_W-1:0]   y_bullet_t,
    input  logic [COORD_W-1:0]   y_bullet_b,
    input  logic                 eb_active,
    input  logic [COORD_W-1:0]   x_bullet_enemy,
    input  logic [COORD_W-1:0]   y_bullet_enemy,
    output logic [IDX_W-1:0]     brick_idx,
    input  logic [COORD_W-1:0]   brick_x,
    input  logic [COORD_W-1:0]   brick_y,
    output logic [NUM_BRICK-1:0] brick_alive,
    output logic                 busy,
    output logic                 scan_done,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 hit_by_enemy,
    output logic [IDX_W-1:0]     enemy_hit_idx
`ifdef BRICK_SCAN_OVERRUN_EN
    ,
    output logic [7:0]           overrun_cnt
`endif
);

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_SCAN  = SCAN;
    localparam logic [1:0]       ST_DONE  = DONE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICK - 1);
    localparam logic [COORD_W:0] EB_EDGE  = (COORD_W+1)'(EBULLET_SIZE - 1);

    logic [1:0]         state;
    logic [COORD_W-1:0] pb_l, pb_r, pb_t, pb_b;
    logic [COORD_W-1:0] eb_x, eb_y;
    logic               pb_act, eb_act;
    logic               pb_done, eb_done;
    logic [IDX_W-1:0]   pb_pend, eb_pend;
    logic [IDX_W-1:0]   hit_idx_q, ehit_idx_q;
    logic               pb_ov, eb_ov;
    logic               pb_take, eb_take;

    brick_overlap #(.BRICK_SIZE(BRICK_SIZE)) u_pb_overlap (
        .box_l   ({1'b0, pb_l}),
        .box_r   ({1'b0, pb_r}),
        .box_t   ({1'b0, pb_t}),
        .box_b   ({1'b0, pb_b}),
        .bx      (brick_x),
        .by      (brick_y),
        .overlap (pb_ov)
    );

    brick_overlap #(.BRICK_SIZE(BRICK_SIZE)) u_eb_overlap (
        .box_l   ({1'b0, eb_x}),
        .box_r   ({1'b0, eb_x} + EB_EDGE),
        .box_t   ({1'b0, eb_y}),
        .box_b   ({1'b0, eb_y} + EB_EDGE),
        .bx      (brick_x),
        .by      (brick_y),
        .overlap (eb_ov)
    );

    // Each bullet takes only its first live brick; a brick cleared earlier in the scan is gone.
    assign pb_take = (state == ST_SCAN) && pb_act && !pb_done && brick_alive[brick_idx] && pb_ov;
    assign eb_take = (state == ST_SCAN) && eb_act && !eb_done && brick_alive[brick_idx] && eb_ov;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            brick_idx   <= '0;
            brick_alive <= '1;
            pb_l        <= '0;
            pb_r        <= '0;
            pb_t        <= '0;
            pb_b        <= '0;
            eb_x        <= '0;
            eb_y        <= '0;
            pb_act      <= 1'b0;
            eb_act      <= 1'b0;
            pb_done     <= 1'b0;
            eb_done     <= 1'b0;
            pb_pend     <= '0;
            eb_pend     <= '0;
            hit_idx_q   <= '0;
            ehit_idx_q  <= '0;
        end else if (load_map) begin
            state       <= ST_IDLE;
            brick_idx   <= '0;
            brick_alive <= '1;
            pb_done     <= 1'b0;
            eb_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refresh_tick) begin
                        pb_l      <= x_bullet_l;
                        pb_r      <= x_bullet_r;
                        pb_t      <= y_bullet_t;
                        pb_b      <= y_bullet_b;
                        eb_x      <= x_bullet_enemy;
                        eb_y      <= y_bullet_enemy;
                        pb_act    <= pb_active;
                        eb_act    <= eb_active;
                        pb_done   <= 1'b0;
                        eb_done   <= 1'b0;
                        brick_idx <= '0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (pb_take) begin
                        pb_done <= 1'b1;
                        pb_pend <= brick_idx;
                    end
                    if (eb_take) begin
                        eb_done <= 1'b1;
                        eb_pend <= brick_idx;
                    end
                    if (pb_take || eb_take) begin
                        brick_alive[brick_idx] <= 1'b0;
                    end
                    if (brick_idx == LAST_IDX) begin
                        brick_idx <= '0;
                        state     <= ST_DONE;
                    end else begin
                        brick_idx <= brick_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Results become visible only here so an aborted scan never disturbs them.
                    if (pb_done) hit_idx_q  <= pb_pend;
                    if (eb_done) ehit_idx_q <= eb_pend;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state == ST_SCAN);
    assign scan_done     = (state == ST_DONE);
    assign hit           = scan_done && pb_done;
    assign hit_by_enemy  = scan_done && eb_done;
    assign hit_idx       = hit ? pb_pend : hit_idx_q;
    assign enemy_hit_idx = hit_by_enemy ? eb_pend : ehit_idx_q;

`ifdef BRICK_SCAN_OVERRUN_EN
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (load_map) begin
            overrun_cnt <= '0;
        end else if (refresh_tick && (state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_brick_scan_ctrl.sv
// tb/tb_brick_scan_ctrl.sv - self-checking bench for brick_scan_ctrl against a frame-level model
module tb_brick_scan_ctrl;

    localparam int NB = 100;
    localparam int IW = 7;
    localparam int BS = 16;
    localparam int ES = 4;

    logic           clk_50MHz = 1'b0;
    logic           reset = 1'b0;
    logic           refresh_tick = 1'b0;
    logic           load_map = 1'b0;
    logic           pb_active = 1'b0;
    logic [9:0]     x_bullet_l = '0, x_bullet_r = '0, y_bullet_t = '0, y_bullet_b = '0;
    logic           eb_active = 1'b0;
    logic [9:0]     x_bullet_enemy = '0, y_bullet_enemy = '0;
    logic [IW-1:0]  brick_idx;
    logic [9:0]     brick_x, brick_y;
    logic [NB-1:0]  brick_alive;
    logic           busy, scan_done, hit, hit_by_enemy;
    logic [IW-1:0]  hit_idx, enemy_hit_idx;
`ifdef BRICK_SCAN_OVERRUN_EN
    logic [7:0]     overrun_cnt;
`endif

    int bx_tab [NB];
    int by_tab [NB];

    logic [NB-1:0] m_alive;
    int            m_hit_idx;
    int            m_ehit_idx;
    int            checks = 0;
    int            errors = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    always_comb begin
        brick_x = '0;
        brick_y = '0;
        if (int'(brick_idx) < NB) begin
            brick_x = 10'(bx_tab[brick_idx]);
            brick_y = 10'(by_tab[brick_idx]);
        end
    end

    brick_scan_ctrl dut (
        .clk_50MHz      (clk_50MHz),
        .reset          (reset),
        .refresh_tick   (refresh_tick),
        .load_map       (load_map),
        .pb_active      (pb_active),
        .x_bullet_l     (x_bullet_l),
        .x_bullet_r     (x_bullet_r),
        .y_bullet_t     (y_bullet_t),
        .y_bullet_b     (y_bullet_b),
        .eb_active      (eb_active),
        .x_bullet_enemy (x_bullet_enemy),
        .y_bullet_enemy (y_bullet_enemy),
        .brick_idx      (brick_idx),
        .brick_x        (brick_x),
        .brick_y        (brick_y),
        .brick_alive    (brick_alive),
        .busy           (busy),
        .scan_done      (scan_done),
        .hit            (hit),
        .hit_idx        (hit_idx),
        .hit_by_enemy   (hit_by_enemy),
        .enemy_hit_idx  (enemy_hit_idx)
`ifdef BRICK_SCAN_OVERRUN_EN
        ,
        .overrun_cnt    (overrun_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ovl(input int l, input int r, input int t, input int b,
                               input int bx, input int by);
        return (t < by + BS - 1) && (b > by) && (l < bx + BS - 1) && (r > bx);
    endfunction

    // Lowest live brick touched by a box; scan order makes this the bullet's victim.
    function automatic int lowest(input int l, input int r, input int t, input int b);
        for (int i = 0; i < NB; i++)
            if (m_alive[i] && ovl(l, r, t, b, bx_tab[i], by_tab[i])) return i;
        return -1;
    endfunction

    task automatic set_pb(input bit act, input int l, input int r, input int t, input int b);
        pb_active  = act;
        x_bullet_l = 10'(l);
        x_bullet_r = 10'(r);
        y_bullet_t = 10'(t);
        y_bullet_b = 10'(b);
    endtask

    task automatic set_eb(input bit act, input int x, input int y);
        eb_active      = act;
        x_bullet_enemy = 10'(x);
        y_bullet_enemy = 10'(y);
    endtask

    task automatic scramble_bullets();
        set_pb(1'b1, 390 + $urandom_range(0, 200), 600, $urandom_range(0, 200), 220);
        set_eb(1'b1, 390 + $urandom_range(0, 200), $urandom_range(0, 200));
    endtask

    task automatic count_done(input string tag, input int cycles, input int exp);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_50MHz);
            if (scan_done) seen++;
        end
        chk(tag, seen, exp);
    endtask

    task automatic frame(input string tag, input bit mid_tick);
        int p, e, n;
        p = pb_active ? lowest(x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b) : -1;
        e = eb_active ? lowest(x_bullet_enemy, x_bullet_enemy + ES - 1,
                               y_bullet_enemy, y_bullet_enemy + ES - 1) : -1;
        @(negedge clk_50MHz);
        refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        refresh_tick = 1'b0;
        n = 1;
        while (!scan_done && n < 300) begin
            if (n == 5) scramble_bullets();
            refresh_tick = mid_tick && (n == 30);
            @(negedge clk_50MHz);
            n++;
        end
        refresh_tick = 1'b0;
        chk({tag, "_latency"}, n, NB + 1);
        chk({tag, "_done"}, scan_done, 1'b1);
        chk({tag, "_hit"}, hit, p >= 0);
        chk({tag, "_hit_by_enemy"}, hit_by_enemy, e >= 0);
        if (p >= 0) begin m_hit_idx = p;  m_alive[p] = 1'b0; end
        if (e >= 0) begin m_ehit_idx = e; m_alive[e] = 1'b0; end
        chk({tag, "_hit_idx"}, hit_idx, m_hit_idx);
        chk({tag, "_enemy_hit_idx"}, enemy_hit_idx, m_ehit_idx);
        @(negedge clk_50MHz);
        chk({tag, "_done_pulse"}, {scan_done, hit, hit_by_enemy, busy}, 4'b0000);
        chk({tag, "_alive"}, brick_alive, m_alive);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NB; i++) begin
            bx_tab[i] = 400 + (i % 10) * 20;
            by_tab[i] = (i / 10) * 20;
        end
        bx_tab[5]  = 304; by_tab[5]  = 400;
        bx_tab[20] = 32;  by_tab[20] = 96;
        bx_tab[21] = 48;  by_tab[21] = 96;
        bx_tab[22] = 64;  by_tab[22] = 96;
        m_alive    = '1;
        m_hit_idx  = 0;
        m_ehit_idx = 0;

        repeat (2) @(negedge clk_50MHz);
        chk("reset_alive", brick_alive, m_alive);
        chk("reset_idx", brick_idx, 0);
        chk("reset_flags", {busy, scan_done, hit, hit_by_enemy}, 4'b0000);
        chk("reset_hit_idx", {hit_idx, enemy_hit_idx}, 0);
        reset = 1'b1;

        set_pb(1'b1, 36, 39, 100, 103);
        set_eb(1'b0, 0, 0);
        frame("single", 1'b0);
        chk("single_idx20", hit_idx, 20);
        chk("single_alive20", brick_alive[20], 1'b0);
        set_pb(1'b1, 36, 39, 100, 103);
        frame("single_again", 1'b0);
        chk("single_again_hit_idx_held", hit_idx, 20);

        set_pb(1'b1, 60, 67, 100, 103);
        frame("lowest", 1'b0);
        chk("lowest_idx21", hit_idx, 21);
        chk("lowest_alive22", brick_alive[22], 1'b1);

        set_pb(1'b1, 305, 308, 401, 404);
        set_eb(1'b1, 306, 402);
        frame("both", 1'b0);
        chk("both_idx", {hit_idx, enemy_hit_idx}, {7'd5, 7'd5});
        chk("both_alive5", brick_alive[5], 1'b0);

        set_pb(1'b0, 402, 405, 82, 85);
        set_eb(1'b0, 0, 0);
        frame("inactive", 1'b0);
        chk("inactive_alive40", brick_alive[40], 1'b1);

        set_pb(1'b1, 462, 465, 2, 5);
        @(negedge clk_50MHz);
        refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        refresh_tick = 1'b0;
        n = 0;
        while (brick_idx != 7'd10 && n < 200) begin
            @(negedge clk_50MHz);
            n++;
        end
        chk("abort_reach_idx10", brick_idx, 10);
        load_map = 1'b1;
        @(negedge clk_50MHz);
        load_map = 1'b0;
        m_alive = '1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_alive", brick_alive, m_alive);
        chk("abort_hit_idx", hit_idx, m_hit_idx);
        count_done("abort_no_done", 120, 0);

        load_map = 1'b1;
        refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        load_map = 1'b0;
        refresh_tick = 1'b0;
        chk("loadtick_busy", busy, 1'b0);
        count_done("loadtick_no_done", 110, 0);

        set_pb(1'b1, 462, 465, 2, 5);
        set_eb(1'b0, 0, 0);
        frame("midtick", 1'b1);
        count_done("midtick_single_done", 130, 0);
`ifdef BRICK_SCAN_OVERRUN_EN
        chk("midtick_overrun", overrun_cnt, 8'd1);
`endif

        for (int k = 0; k < 10; k++) begin
            set_pb($urandom_range(0, 3) != 0, 0, 0, 0, 0);
            x_bullet_l = 10'(390 + $urandom_range(0, 200));
            x_bullet_r = x_bullet_l + 10'($urandom_range(1, 8));
            y_bullet_t = 10'($urandom_range(0, 200));
            y_bullet_b = y_bullet_t + 10'($urandom_range(1, 8));
            set_eb($urandom_range(0, 3) != 0, 390 + $urandom_range(0, 200), $urandom_range(0, 200));
            frame("random", 1'b0);
        end

        set_pb(1'b1, 402, 405, 82, 85);
        @(negedge clk_50MHz);
        refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        refresh_tick = 1'b0;
        n = 0;
        while (brick_idx != 7'd50 && n < 200) begin
            @(negedge clk_50MHz);
            n++;
        end
        chk("rst_reach_idx50", brick_idx, 50);
        reset = 1'b0;
        #1;
        chk("rst_mid_alive", brick_alive, {NB{1'b1}});
        chk("rst_mid_idx", brick_idx, 0);
        chk("rst_mid_flags", {busy, scan_done, hit, hit_by_enemy}, 4'b0000);
        chk("rst_mid_hit_idx", {hit_idx, enemy_hit_idx}, 0);
`ifdef BRICK_SCAN_OVERRUN_EN
        chk("rst_mid_overrun", overrun_cnt, 0);
`endif
        @(negedge clk_50MHz);
        reset = 1'b1;
        @(negedge clk_50MHz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brick_scan_ctrl.md
Name: brick_scan_ctrl

Overview:
- Sequential collision scheduler for the brick map. On each refresh_tick it samples the player and enemy bullet positions, then walks every brick index once, one per clock, through a shared brick-position lookup.
- It owns the per-brick alive bitmap and arbitrates destruction when both bullets hit bricks in the same frame. It reports one-cycle hit results to the tank/bullet logic.
- It sits between the brick position table, the bullet controllers and the renderer (brick_alive gates brick_on).

Parameters:
- NUM_BRICK, 100, number of bricks in the map; brick indices 0..NUM_BRICK-1.
- BRICK_SIZE, 16, brick edge in pixels; the brick occupies [bx, bx+BRICK_SIZE-1].
- EBULLET_SIZE, 4, enemy bullet edge in pixels; the box is [xe, xe+EBULLET_SIZE-1].

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  frame-start pulse; starts a scan.
- load_map  in  1  pulse; revives all bricks and aborts any scan in progress.
- pb_active  in  1  player bullet in flight.
- x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b  in  10 each  player bullet box.
- eb_active  in  1  enemy bullet in flight.
- x_bullet_enemy, y_bullet_enemy  in  10 each  enemy bullet top-left corner.
- brick_idx  out  IDX_W=$clog2(NUM_BRICK)  lookup address.
- brick_x, brick_y  in  10 each  brick top-left for brick_idx; combinational, same cycle.
- brick_alive  out  NUM_BRICK  1 = brick present.
- busy  out  1  high in SCAN.
- scan_done  out  1  one-cycle pulse at the end of each completed scan.
- hit  out  1  one-cycle pulse, valid with scan_done: player bullet destroyed a brick.
- hit_idx  out  IDX_W  index destroyed by the player bullet; held until the next scan_done.
- hit_by_enemy  out  1  one-cycle pulse, valid with scan_done: enemy bullet destroyed a brick.
- enemy_hit_idx  out  IDX_W  index destroyed by the enemy bullet; held until the next scan_done.

Behaviour:
- Reset values: state IDLE, brick_alive all ones, brick_idx 0, busy 0, scan_done 0, hit 0, hit_by_enemy 0, hit_idx 0, enemy_hit_idx 0.
- FSM states are IDLE, SCAN and DONE.
- IDLE -> SCAN on refresh_tick.
  - Register the bullet coordinates and active flags; brick_idx <= 0.
  - Clear the per-scan flags pb_done and eb_done.
- SCAN compares the snapshot against brick_x/brick_y each cycle, then increments brick_idx. After index NUM_BRICK-1 it goes to DONE.
- DONE: assert scan_done, hit and hit_by_enemy for exactly one cycle, then return to IDLE.
- Latency: a tick in cycle t gives scan_done in cycle t+NUM_BRICK+1.
- Overlap test, all arithmetic 11 bits wide, no wrap:
  - (yt < by+BRICK_SIZE-1) and (yb > by) and (xl < bx+BRICK_SIZE-1) and (xr > bx).
  - Enemy box: xl=xe, xr=xe+EBULLET_SIZE-1, yt=ye, yb=ye+EBULLET_SIZE-1.
- A bullet counts only if it is active, its done flag is clear, and brick_alive[idx] is 1.
- On a counted hit: brick_alive[idx] <= 0, set that bullet's done flag, and latch its index register. Result: at most one brick per bullet per frame, and it is the lowest matching index.
- Both bullets hitting the same brick in the same cycle: the brick is cleared once, and both bullets are credited with that index.
- A brick already cleared earlier in the scan is not hittable again.
- refresh_tick during SCAN or DONE is ignored; no restart.
- load_map in any state:
  - brick_alive <= all ones, state <= IDLE.
  - No scan_done or hit pulses for an aborted scan. hit_idx and enemy_hit_idx keep their values.
  - load_map and refresh_tick in the same cycle: load_map wins; the tick is dropped.
- Bullet inputs that change during SCAN have no effect (the snapshot is used).
- Asynchronous reset mid-scan returns immediately to the reset values.

Optional Feature:
- Macro: BRICK_SCAN_OVERRUN_EN.
- Defined: adds output overrun_cnt (8 bits, resets to 0).
  - Increments when refresh_tick arrives while not in IDLE.
  - Saturates at 255; cleared by load_map.
- Undefined: no port; dropped ticks are silently ignored.

Decomposition:
- Package brick_pkg holds:
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  - localparams COORD_W=10, BRICK_SIZE_DEF=16, EBULLET_SIZE_DEF=4.
- One combinational sub-module, brick_overlap: inputs are the box l/r/t/b plus bx/by, output is overlap. It is instantiated twice, once per bullet.

Test Plan:
- Brick 20 at (32,96); player box l=36 r=39 t=100 b=103, pb_active=1; tick at cycle 0 -> scan_done and hit at cycle NUM_BRICK+1, hit_idx=20, brick_alive[20]=0. A second tick gives hit=0.
- Player box overlapping bricks 21 (48,96) and 22 (64,96), l=60 r=67 -> only brick 21 cleared, hit_idx=21, brick_alive[22]=1.
- Both bullets on brick 5 (304,400) in one frame, enemy at (306,402) -> brick_alive[5]=0, hit=hit_by_enemy=1, hit_idx=enemy_hit_idx=5.
- load_map at scan index 10 with a pending hit on brick 3 -> IDLE, no scan_done, brick_alive all ones.
- Tick during SCAN -> ignored; exactly one scan_done. With BRICK_SCAN_OVERRUN_EN, overrun_cnt=1.
- pb_active=0 with a geometrically overlapping box -> hit=0, brick stays alive. Reset asserted mid-scan -> all outputs at reset values.
